// File: rtl/pwm_pkg.sv
// Shared constants, the clog2 helper and the button-event encoding for the multi-channel PWM.
package pwm_pkg;

  localparam int unsigned DefNCh        = 4;
  localparam int unsigned DefPeriod     = 2500;
  localparam int unsigned DefDutyInit   = 1250;
  localparam int unsigned DefDutyMin    = 125;
  localparam int unsigned DefDutyMax    = 2500;
  localparam int unsigned DefStep       = 125;
  localparam int unsigned DefDebCycles  = 500000;
  localparam int unsigned DefRepDelay   = 25000000;
  localparam int unsigned DefRepRate    = 5000000;

  typedef enum logic [1:0] {
    EvNone = 2'd0,
    EvInc  = 2'd1,
    EvDec  = 2'd2
  } ev_e;

  // Ceiling log2; clog2(1) == 0, so callers clamp to 1 where a width is needed.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Button inputs, channel select and PWM/duty outputs of pwm_multi.
interface pwm_multi_if
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 12
);
  localparam int unsigned SelW = (clog2(N_CH) < 1) ? 1 : clog2(N_CH);

  logic            pb_inc;
  logic            pb_dec;
  logic [SelW-1:0] ch_sel;
  logic [N_CH-1:0] pwm_out;
  logic [DW-1:0]   duty_sel;

  modport master (output pb_inc, pb_dec, ch_sel, input pwm_out, duty_sel);
  modport slave  (input pb_inc, pb_dec, ch_sel, output pwm_out, duty_sel);

endinterface

// File: rtl/pb_debounce.sv
// One push-button path: 2-flop synchronizer, debounce counter and press/auto-repeat event pulse.
module pb_debounce
  import pwm_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DefDebCycles,
  parameter int unsigned REPEAT_DELAY = DefRepDelay,
  parameter int unsigned REPEAT_RATE  = DefRepRate
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pb_ni,
  input  logic hold_i,
  output logic level_o,
  output logic event_o
);

  localparam int unsigned DebW   = (clog2(DEB_CYCLES + 1) < 1) ? 1 : clog2(DEB_CYCLES + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = (clog2(RepMax + 1) < 1) ? 1 : clog2(RepMax + 1);
  localparam logic [DebW-1:0] DebLast  = DebW'(DEB_CYCLES - 1);
  localparam logic [RepW-1:0] RepDelay = RepW'(REPEAT_DELAY);
  localparam logic [RepW-1:0] RepRate  = RepW'(REPEAT_RATE);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_first_q, rep_first_d;
  logic            event_q, event_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= 2'b11;
      level_q     <= 1'b1;
      deb_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      event_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], pb_ni};
      level_q     <= level_d;
      deb_cnt_q   <= deb_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      event_q     <= event_d;
    end
  end

  always_comb begin
    level_d     = level_q;
    deb_cnt_d   = '0;
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
    event_d     = 1'b0;
    if (sync_q[1] != level_q) begin
      if (deb_cnt_q == DebLast) level_d = sync_q[1];
      else                      deb_cnt_d = deb_cnt_q + 1'b1;
    end
    if (level_q && !level_d) begin
      event_d = 1'b1;
    end else if (!level_q && !level_d && !hold_i) begin
      // First repeat waits the long delay, later ones the short rate.
      rep_first_d = rep_first_q;
      rep_cnt_d   = rep_cnt_q + 1'b1;
      if (rep_cnt_d == (rep_first_q ? RepDelay : RepRate)) begin
        event_d     = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end
    end
  end

  assign level_o = level_q;
  assign event_o = event_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel phase-staggered PWM with shadowed duty stepped by two debounced push-buttons.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH         = DefNCh,
  parameter int unsigned PERIOD       = DefPeriod,
  parameter int unsigned DUTY_INIT    = DefDutyInit,
  parameter int unsigned DUTY_MIN     = DefDutyMin,
  parameter int unsigned DUTY_MAX     = DefDutyMax,
  parameter int unsigned STEP         = DefStep,
  parameter int unsigned DEB_CYCLES   = DefDebCycles,
  parameter int unsigned REPEAT_DELAY = DefRepDelay,
  parameter int unsigned REPEAT_RATE  = DefRepRate
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  pwm_multi_if.slave   bus
);

  localparam int unsigned DW   = clog2(PERIOD + 1);
  localparam int unsigned SelW = (clog2(N_CH) < 1) ? 1 : clog2(N_CH);
  localparam logic [DW-1:0] CntLast = DW'(PERIOD - 1);

  logic inc_level, dec_level, inc_ev, dec_ev, both_low;
  ev_e  ev;

  assign both_low = !inc_level && !dec_level;

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_pb_inc (.clk_i(clk_i), .rst_ni(rst_ni), .pb_ni(bus.pb_inc), .hold_i(both_low),
              .level_o(inc_level), .event_o(inc_ev));

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_pb_dec (.clk_i(clk_i), .rst_ni(rst_ni), .pb_ni(bus.pb_dec), .hold_i(both_low),
              .level_o(dec_level), .event_o(dec_ev));

  logic [SelW-1:0]   sel;
  logic              sel_ok;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     shadow_q [N_CH];
  logic [DW-1:0]     shadow_d [N_CH];
  logic [DW-1:0]     duty_sel_q, duty_sel_d;
  logic [DW:0]       sum;
  logic signed [DW:0] diff;

  assign sel    = bus.ch_sel;
  assign sel_ok = (32'(sel) < N_CH);

  always_comb begin
    ev = EvNone;
    if (!both_low) begin
      if (inc_ev)      ev = EvInc;
      else if (dec_ev) ev = EvDec;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    sum      = '0;
    diff     = '0;
    cnt_d    = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    if (sel_ok) begin
      case (ev)
        EvInc: begin
          sum = {1'b0, shadow_q[sel]} + (DW+1)'(STEP);
          shadow_d[sel] = (sum > (DW+1)'(DUTY_MAX)) ? DW'(DUTY_MAX) : sum[DW-1:0];
        end
        EvDec: begin
          diff = $signed({1'b0, shadow_q[sel]}) - $signed((DW+1)'(STEP));
          shadow_d[sel] = (diff < $signed((DW+1)'(DUTY_MIN))) ? DW'(DUTY_MIN) : diff[DW-1:0];
        end
        default: ;
      endcase
    end
    duty_sel_d = sel_ok ? shadow_d[sel] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      duty_sel_q <= '0;
      for (int i = 0; i < N_CH; i++) shadow_q[i] <= DW'(DUTY_INIT);
    end else begin
      cnt_q      <= cnt_d;
      duty_sel_q <= duty_sel_d;
      shadow_q   <= shadow_d;
    end
  end

  assign bus.duty_sel = duty_sel_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam int unsigned Off = k * (PERIOD / N_CH);
    logic [DW:0]   ph_sum;
    logic [DW-1:0] ph;
    logic [DW-1:0] act_q;
    logic          pwm_q;

    assign ph_sum = {1'b0, cnt_q} + (DW+1)'(Off);
    assign ph     = (ph_sum >= (DW+1)'(PERIOD)) ? DW'(ph_sum - (DW+1)'(PERIOD)) : ph_sum[DW-1:0];

    // Active duty only reloads on the last phase, so a new duty starts cleanly at ph == 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        act_q <= DW'(DUTY_INIT);
        pwm_q <= 1'b0;
      end else begin
        pwm_q <= (ph < act_q);
        if (ph == CntLast) act_q <= shadow_q[k];
      end
    end

    assign bus.pwm_out[k] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: spec-level model compared every cycle, plus hand-computed spot checks.
module tb_pwm_multi;

  localparam int NC = 4, P = 20, DINIT = 10, DMIN = 2, DMAX = 18, STEP = 2;
  localparam int DEB = 4, RD = 40, RR = 10, DW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_multi_if #(.N_CH(NC), .DW(DW)) bus ();

  pwm_multi #(
    .N_CH(NC), .PERIOD(P), .DUTY_INIT(DINIT), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .STEP(STEP),
    .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model state: per-channel shadow/active duty, cycle count since reset, button paths.
  int t;
  int shadow [NC];
  int act [NC];
  int exp_pwm [NC];
  int exp_sel;
  bit s1 [2], s2 [2], deb [2], ev [2];
  int run [2], age [2];

  always @(posedge clk or negedge rst_n) begin : model
    bit raw [2];
    bit nd [2];
    bit nev [2];
    bit both_now;
    int ph, s;
    if (!rst_n) begin
      t = 0;
      exp_sel = 0;
      for (int k = 0; k < NC; k++) begin
        shadow[k] = DINIT; act[k] = DINIT; exp_pwm[k] = 0;
      end
      for (int b = 0; b < 2; b++) begin
        s1[b] = 1; s2[b] = 1; deb[b] = 1; ev[b] = 0; run[b] = 0; age[b] = 0;
      end
    end else begin
      raw[0] = bus.pb_inc;
      raw[1] = bus.pb_dec;
      s = int'(bus.ch_sel);
      for (int k = 0; k < NC; k++) begin
        ph = (t + k * (P / NC)) % P;
        exp_pwm[k] = (ph < act[k]) ? 1 : 0;
        if (ph == P - 1) act[k] = shadow[k];
      end
      both_now = !deb[0] && !deb[1];
      if (!both_now && s < NC) begin
        if (ev[0])      shadow[s] = (shadow[s] + STEP > DMAX) ? DMAX : shadow[s] + STEP;
        else if (ev[1]) shadow[s] = (shadow[s] - STEP < DMIN) ? DMIN : shadow[s] - STEP;
      end
      exp_sel = (s < NC) ? shadow[s] : 0;
      for (int b = 0; b < 2; b++) begin
        nd[b] = deb[b];
        if (s2[b] != deb[b]) begin
          run[b]++;
          if (run[b] == DEB) begin
            nd[b] = s2[b];
            run[b] = 0;
          end
        end else begin
          run[b] = 0;
        end
        nev[b] = 0;
        if (deb[b] && !nd[b]) begin
          nev[b] = 1;
          age[b] = 0;
        end else if (!deb[b] && !nd[b]) begin
          if (both_now) age[b] = 0;
          else begin
            age[b]++;
            nev[b] = (age[b] == RD) || (age[b] > RD && (age[b] - RD) % RR == 0);
          end
        end else begin
          age[b] = 0;
        end
      end
      for (int b = 0; b < 2; b++) begin
        ev[b] = nev[b]; deb[b] = nd[b]; s2[b] = s1[b]; s1[b] = raw[b];
      end
      t++;
    end
  end

  always @(negedge clk) begin : compare
    for (int k = 0; k < NC; k++) chk($sformatf("pwm_out[%0d]", k), int'(bus.pwm_out[k]), exp_pwm[k]);
    chk("duty_sel", int'(bus.duty_sel), exp_sel);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // btn 0 = inc, 1 = dec
  task automatic press(input int btn, input int low_n, input int high_n);
    @(negedge clk);
    if (btn == 0) bus.pb_inc = 1'b0; else bus.pb_dec = 1'b0;
    cycles(low_n);
    if (btn == 0) bus.pb_inc = 1'b1; else bus.pb_dec = 1'b1;
    cycles(high_n);
  endtask

  // High count and last rising-edge index of each channel over one period.
  task automatic window(output int hi [NC], output int rise [NC]);
    logic [NC-1:0] prev;
    prev = bus.pwm_out;
    for (int k = 0; k < NC; k++) begin hi[k] = 0; rise[k] = -1; end
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      for (int k = 0; k < NC; k++) begin
        if (bus.pwm_out[k]) hi[k]++;
        if (!prev[k] && bus.pwm_out[k]) rise[k] = i;
      end
      prev = bus.pwm_out;
    end
  endtask

  int hi [NC];
  int rise [NC];

  initial begin
    bus.pb_inc = 1'b1;
    bus.pb_dec = 1'b1;
    bus.ch_sel = '0;
    cycles(3);
    #1;
    chk("rst_pwm", int'(bus.pwm_out), 0);
    chk("rst_duty_sel", int'(bus.duty_sel), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_pwm0", int'(bus.pwm_out[0]), 1);
    chk("first_duty_sel", int'(bus.duty_sel), 10);

    // Steady state and phase stagger
    cycles(20);
    window(hi, rise);
    for (int k = 0; k < NC; k++) chk($sformatf("init_high[%0d]", k), hi[k], 10);
    for (int k = 1; k < NC; k++)
      chk($sformatf("lead[%0d]", k), (rise[0] - rise[k] + P) % P, 5 * k);

    // Single inc on ch1
    bus.ch_sel = 2'd1;
    press(0, 10, 14);
    chk("inc_duty_sel", int'(bus.duty_sel), 12);
    cycles(40);
    window(hi, rise);
    chk("inc_high1", hi[1], 12);
    chk("inc_high0", hi[0], 10);
    chk("inc_high2", hi[2], 10);
    chk("inc_high3", hi[3], 10);

    // Bounce rejection on ch3
    @(negedge clk);
    bus.ch_sel = 2'd3;
    for (int i = 0; i < 10; i++) begin
      bus.pb_inc = (i % 2 == 0) ? 1'b0 : 1'b1;
      cycles(2);
    end
    cycles(8);
    chk("bounce_none", int'(bus.duty_sel), 10);
    press(0, 10, 14);
    chk("bounce_one", int'(bus.duty_sel), 12);

    // Saturation on ch0
    bus.ch_sel = 2'd0;
    repeat (6) press(1, 10, 12);
    chk("sat_min", int'(bus.duty_sel), 2);
    repeat (10) press(0, 10, 12);
    chk("sat_max", int'(bus.duty_sel), 18);

    // Auto-repeat on ch2: press + 3 repeats
    bus.ch_sel = 2'd2;
    press(1, 65, 20);
    chk("repeat_duty", int'(bus.duty_sel), 2);
    cycles(30);
    chk("repeat_stop", int'(bus.duty_sel), 2);

    // Conflict, then reset mid-period with both buttons down
    bus.ch_sel = 2'd1;
    @(negedge clk);
    bus.pb_inc = 1'b0;
    bus.pb_dec = 1'b0;
    cycles(100);
    chk("conflict_duty", int'(bus.duty_sel), 12);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_pwm", int'(bus.pwm_out), 0);
    chk("midrst_duty_sel", int'(bus.duty_sel), 0);
    bus.pb_inc = 1'b1;
    bus.pb_dec = 1'b1;
    cycles(2);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_pwm0", int'(bus.pwm_out[0]), 1);
    chk("post_rst_duty_sel", int'(bus.duty_sel), 10);
    cycles(19);
    window(hi, rise);
    for (int k = 0; k < NC; k++) chk($sformatf("post_rst_high[%0d]", k), hi[k], 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
